// File: rtl/mantissa_aligner_if.sv
// Lane-bundle handshake between the exponent normalizer, the mantissa aligner
// and the downstream adder tree.
interface mantissa_aligner_if #(
  parameter int expWidth = 4,
  parameter int manWidth = 4
) ();
  localparam int alnWidth = manWidth + 3;

  logic                    in_valid;
  logic                    in_ready;
  logic [4*manWidth-1:0]   input_man;
  logic [3:0]              input_sign;
  logic [expWidth-1:0]     max_exp;
  logic [4*expWidth-1:0]   exp_offset_num;
  logic                    out_valid;
  logic                    out_ready;
  logic [4*alnWidth-1:0]   aligned_man;
  logic [3:0]              aligned_sign;
  logic [expWidth-1:0]     aligned_exp;

  modport master (
    output in_valid, input_man, input_sign, max_exp, exp_offset_num, out_ready,
    input  in_ready, out_valid, aligned_man, aligned_sign, aligned_exp
  );

  modport slave (
    input  in_valid, input_man, input_sign, max_exp, exp_offset_num, out_ready,
    output in_ready, out_valid, aligned_man, aligned_sign, aligned_exp
  );
endinterface

// File: rtl/mantissa_aligner.sv
// Two-stage pipeline that right-shifts four lane mantissas onto the common
// exponent, producing mantissa+guard+round+sticky per lane.
module mantissa_aligner #(
  parameter int expWidth = 4,
  parameter int manWidth = 4
) (
  input logic              clk,
  input logic              rst_n,
  mantissa_aligner_if.slave bus
);
  localparam int alnWidth = manWidth + 3;

  // Shift one lane right by off; every bit pushed out folds into bit 0.
  function automatic logic [alnWidth-1:0] align_lane(
    input logic [manWidth-1:0] man,
    input logic [expWidth-1:0] off
  );
    logic [alnWidth-1:0] ext;
    logic [alnWidth-1:0] lost_mask;
    logic [alnWidth-1:0] res;
    ext = {man, 3'b000};
    if (int'(off) >= alnWidth) begin
      res    = '0;
      res[0] = |man;
    end else begin
      lost_mask = ~({alnWidth{1'b1}} << off);
      res       = ext >> off;
      res[0]    = res[0] | (|(ext & lost_mask));
    end
    return res;
  endfunction

  logic                    adv_s;
  logic                    s1_valid_q;
  logic [4*manWidth-1:0]   s1_man_q;
  logic [3:0]              s1_sign_q;
  logic [expWidth-1:0]     s1_exp_q;
  logic [4*expWidth-1:0]   s1_off_q;
  logic                    out_valid_q;
  logic [4*alnWidth-1:0]   aln_d;
  logic [4*alnWidth-1:0]   aln_q;
  logic [3:0]              sign_q;
  logic [expWidth-1:0]     exp_q;

  // A single enable moves the whole pipe, so a stall freezes both stages together.
  assign adv_s            = ~out_valid_q | bus.out_ready;
  assign bus.in_ready     = adv_s;
  assign bus.out_valid    = out_valid_q;
  assign bus.aligned_man  = aln_q;
  assign bus.aligned_sign = sign_q;
  assign bus.aligned_exp  = exp_q;

  // Stage 1 input capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_man_q   <= '0;
      s1_sign_q  <= 4'b0000;
      s1_exp_q   <= '0;
      s1_off_q   <= '0;
    end else if (adv_s) begin
      s1_valid_q <= bus.in_valid;
      s1_man_q   <= bus.input_man;
      s1_sign_q  <= bus.input_sign;
      s1_exp_q   <= bus.max_exp;
      s1_off_q   <= bus.exp_offset_num;
    end
  end

  // Per-lane alignment of the stage-1 contents.
  always_comb begin
    aln_d = '0;
    for (int i = 0; i < 4; i++) begin
      aln_d[i*alnWidth +: alnWidth] =
        align_lane(s1_man_q[i*manWidth +: manWidth], s1_off_q[i*expWidth +: expWidth]);
    end
  end

  // Stage 2 result register driving the outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      aln_q       <= '0;
      sign_q      <= 4'b0000;
      exp_q       <= '0;
    end else if (adv_s) begin
      out_valid_q <= s1_valid_q;
      aln_q       <= aln_d;
      sign_q      <= s1_sign_q;
      exp_q       <= s1_exp_q;
    end
  end
endmodule

// File: tb/tb_mantissa_aligner.sv
// Self-checking bench for mantissa_aligner: directed table, stall/reset
// sequences and a randomized queue-based scoreboard.
module tb_mantissa_aligner;
  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  mantissa_aligner_if #(.expWidth(4), .manWidth(4)) bus ();
  mantissa_aligner #(.expWidth(4), .manWidth(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] man;
    logic [3:0] off;
    logic [3:0] sign;
    logic [3:0] mexp;
    logic [6:0] res;
  } vec_t;

  vec_t tbl [8];
  logic [35:0] sb_q [$];

  // Reference: value man*8 divided by 2**off, any nonzero remainder sets bit 0.
  function automatic logic [6:0] ref_lane(input logic [3:0] man, input logic [3:0] off);
    int v, d, r;
    v = int'(man) * 8;
    if (int'(off) >= 7) begin
      r = (man != 4'd0) ? 1 : 0;
    end else begin
      d = 1 << off;
      r = v / d;
      if ((v % d) != 0) r = r | 1;
    end
    return r[6:0];
  endfunction

  function automatic logic [27:0] ref_bundle(input logic [15:0] man, input logic [15:0] off);
    logic [27:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) r[i*7 +: 7] = ref_lane(man[i*4 +: 4], off[i*4 +: 4]);
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    n_vec++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] man, input logic [15:0] off,
                       input logic [3:0] sign, input logic [3:0] mexp);
    bus.in_valid       = v;
    bus.input_man      = man;
    bus.exp_offset_num = off;
    bus.input_sign     = sign;
    bus.max_exp        = mexp;
  endtask

  function automatic logic [35:0] out_word();
    return {bus.aligned_sign, bus.aligned_exp, bus.aligned_man};
  endfunction

  initial begin
    logic [35:0] wa, wb, wc, wd, hold_w;
    logic [35:0] tp_exp [8];
    logic [15:0] rm, ro;
    logic [3:0]  rs, re;
    logic        hold_f;

    n_vec = 0;
    n_err = 0;
    clk   = 1'b0;
    rst_n = 1'b0;
    bus.out_ready = 1'b1;
    drive(1'b0, 16'h0000, 16'h0000, 4'h0, 4'h0);

    tbl[0] = '{4'b1011, 4'd0,  4'b0000, 4'h0, 7'b1011000};
    tbl[1] = '{4'b1011, 4'd2,  4'b1010, 4'hC, 7'b0010110};
    tbl[2] = '{4'b1011, 4'd4,  4'b0101, 4'h3, 7'b0000101};
    tbl[3] = '{4'b1011, 4'd5,  4'b1010, 4'hC, 7'b0000011};
    tbl[4] = '{4'b1011, 4'd15, 4'b1111, 4'hF, 7'b0000001};
    tbl[5] = '{4'b0000, 4'd15, 4'b1010, 4'hC, 7'b0000000};
    tbl[6] = '{4'b1000, 4'd3,  4'b0001, 4'h7, 7'b0001000};
    tbl[7] = '{4'b1111, 4'd6,  4'b1000, 4'h1, 7'b0000001};

    // Reset state
    #12;
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_outputs", 64'(out_word()), 64'd0);
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    rst_n = 1'b1;
    tick();
    check("post_rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("post_rst_out_valid", 64'(bus.out_valid), 64'd0);

    // Directed table: same lane value replicated on all four lanes
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, {4{tbl[k].man}}, {4{tbl[k].off}}, tbl[k].sign, tbl[k].mexp);
      tick();
      drive(1'b0, 16'h0000, 16'h0000, 4'h0, 4'h0);
      check("tbl_latency1", 64'(bus.out_valid), 64'd0);
      tick();
      check("tbl_valid", 64'(bus.out_valid), 64'd1);
      check("tbl_man", 64'(bus.aligned_man), 64'({tbl[k].res, tbl[k].res, tbl[k].res, tbl[k].res}));
      check("tbl_side", 64'({bus.aligned_sign, bus.aligned_exp}), 64'({tbl[k].sign, tbl[k].mexp}));
    end
    tick();
    check("tbl_drain", 64'(bus.out_valid), 64'd0);

    // Stall: A at the output, B in stage 1, C waiting at the input
    wa = {4'b0011, 4'h5, ref_bundle(16'h9B3F, 16'h0274)};
    wb = {4'b1100, 4'hA, ref_bundle(16'h1E07, 16'hF851)};
    wc = {4'b0110, 4'h2, ref_bundle(16'hC0D9, 16'h3A6E)};
    drive(1'b1, 16'h9B3F, 16'h0274, 4'b0011, 4'h5);
    tick();
    drive(1'b1, 16'h1E07, 16'hF851, 4'b1100, 4'hA);
    tick();
    bus.out_ready = 1'b0;
    drive(1'b1, 16'hC0D9, 16'h3A6E, 4'b0110, 4'h2);
    #1;
    check("stall_in_ready", 64'(bus.in_ready), 64'd0);
    check("stall_A", 64'(out_word()), 64'(wa));
    for (int k = 0; k < 3; k++) begin
      tick();
      check("stall_hold_valid", 64'(bus.out_valid), 64'd1);
      check("stall_hold_A", 64'(out_word()), 64'(wa));
      check("stall_hold_ready", 64'(bus.in_ready), 64'd0);
    end
    bus.out_ready = 1'b1;
    #1;
    check("unstall_in_ready", 64'(bus.in_ready), 64'd1);
    tick();
    drive(1'b0, 16'h0000, 16'h0000, 4'h0, 4'h0);
    check("unstall_B_valid", 64'(bus.out_valid), 64'd1);
    check("unstall_B", 64'(out_word()), 64'(wb));
    tick();
    check("unstall_C_valid", 64'(bus.out_valid), 64'd1);
    check("unstall_C", 64'(out_word()), 64'(wc));
    tick();
    check("unstall_empty", 64'(bus.out_valid), 64'd0);

    // Reset with both stages full
    drive(1'b1, 16'hFFFF, 16'h0000, 4'b1111, 4'hF);
    tick();
    drive(1'b1, 16'h7777, 16'h1111, 4'b0101, 4'h9);
    tick();
    drive(1'b0, 16'h0000, 16'h0000, 4'h0, 4'h0);
    check("pre_rst_valid", 64'(bus.out_valid), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", 64'(bus.out_valid), 64'd0);
    check("async_rst_outputs", 64'(out_word()), 64'd0);
    check("async_rst_in_ready", 64'(bus.in_ready), 64'd1);
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("rst_no_ghost", 64'(bus.out_valid), 64'd0);
    end
    wd = {4'b1001, 4'h6, ref_bundle(16'h5A3C, 16'h9630)};
    drive(1'b1, 16'h5A3C, 16'h9630, 4'b1001, 4'h6);
    tick();
    drive(1'b0, 16'h0000, 16'h0000, 4'h0, 4'h0);
    check("rst_new_lat1", 64'(bus.out_valid), 64'd0);
    tick();
    check("rst_new_valid", 64'(bus.out_valid), 64'd1);
    check("rst_new_data", 64'(out_word()), 64'(wd));
    tick();

    // Throughput: 8 random bundles back to back
    for (int c = 0; c < 10; c++) begin
      if (c < 8) begin
        rm = 16'($urandom);
        ro = 16'($urandom);
        rs = 4'($urandom);
        re = 4'($urandom);
        tp_exp[c] = {rs, re, ref_bundle(rm, ro)};
        drive(1'b1, rm, ro, rs, re);
      end else begin
        drive(1'b0, 16'h0000, 16'h0000, 4'h0, 4'h0);
      end
      #1;
      if (c >= 2) begin
        check("tput_valid", 64'(bus.out_valid), 64'd1);
        check("tput_data", 64'(out_word()), 64'(tp_exp[c-2]));
      end
      tick();
    end
    #1;
    check("tput_end", 64'(bus.out_valid), 64'd0);

    // Random traffic with random back-pressure against a FIFO scoreboard
    hold_f = 1'b0;
    hold_w = '0;
    for (int c = 0; c < 400; c++) begin
      rm = 16'($urandom);
      if ($urandom_range(0, 7) == 0) rm[7:4] = 4'h0;
      drive(1'($urandom_range(0, 1)), rm, 16'($urandom), 4'($urandom), 4'($urandom));
      bus.out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (hold_f) begin
        check("sb_hold_valid", 64'(bus.out_valid), 64'd1);
        check("sb_hold_data", 64'(out_word()), 64'(hold_w));
      end
      hold_f = bus.out_valid && !bus.out_ready;
      hold_w = out_word();
      if (bus.out_valid && bus.out_ready) begin
        if (sb_q.size() == 0) begin
          check("sb_unexpected", 64'd1, 64'd0);
        end else begin
          check("sb_data", 64'(out_word()), 64'(sb_q.pop_front()));
        end
      end
      if (bus.in_valid && bus.in_ready)
        sb_q.push_back({bus.input_sign, bus.max_exp, ref_bundle(bus.input_man, bus.exp_offset_num)});
      tick();
    end
    drive(1'b0, 16'h0000, 16'h0000, 4'h0, 4'h0);
    bus.out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      if (bus.out_valid) begin
        if (sb_q.size() == 0) begin
          check("sb_drain_unexpected", 64'd1, 64'd0);
        end else begin
          check("sb_drain_data", 64'(out_word()), 64'(sb_q.pop_front()));
        end
      end
      tick();
    end
    check("sb_empty", 64'(sb_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/mantissa_aligner.md
MANTISSA_ALIGNER -- requirements
Module: mantissa_aligner

Interface
REQ-001 Parameter expWidth, default 4: exponent field width per lane.
REQ-002 Parameter manWidth, default 4: mantissa width per lane, hidden bit included.
REQ-003 Derived alnWidth = manWidth+3: aligned lane width (mantissa, guard, round, sticky).
REQ-004 clk  input  1  rising-edge clock; sole clock of the block.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 in_valid  input  1  upstream lane bundle valid.
REQ-007 in_ready  output  1  block accepts bundle this cycle.
REQ-008 input_man  input  4*manWidth  four unsigned mantissas; lane i = bits [i*manWidth +: manWidth].
REQ-009 input_sign  input  4  per-lane sign; bit i = lane i.
REQ-010 max_exp  input  expWidth  common (largest) exponent from the upstream exponent normalizer.
REQ-011 exp_offset_num  input  4*expWidth  per-lane right-shift distance (max_exp minus lane exponent), unsigned; lane i = bits [i*expWidth +: expWidth].
REQ-012 out_valid  output  1  aligned bundle valid.
REQ-013 out_ready  input  1  downstream accepts bundle.
REQ-014 aligned_man  output  4*alnWidth  aligned mantissas; lane i = bits [i*alnWidth +: alnWidth].
REQ-015 aligned_sign  output  4  input_sign carried with its bundle.
REQ-016 aligned_exp  output  expWidth  max_exp carried with its bundle.

Function
REQ-017 Two-stage register pipeline: S1 captures inputs, S2 holds the shifted result; fixed latency 2 cycles from accepted input to out_valid with no stall.
REQ-018 Global enable adv = !out_valid || out_ready; both stages and their valid bits update only when adv=1.
REQ-019 in_ready = adv, combinational; a bundle is accepted when in_valid && in_ready.
REQ-020 When adv=1: S1 valid <= in_valid; S2 valid (out_valid) <= S1 valid; data registers load even when the corresponding valid is 0.
REQ-021 When adv=0, all S1/S2 registers hold; out_valid and all outputs remain stable until out_ready=1 (no drop, no duplicate).
REQ-022 Per lane, S2 computes t = {man, 3'b000} >> off, with off the lane's exp_offset_num field; bits shifted past the LSB are OR-reduced and ORed into result bit 0 (sticky).
REQ-023 For off >= alnWidth, the lane result is all zeros except bit 0 = OR of the lane mantissa.
REQ-024 A zero mantissa yields a zero aligned lane for any off.
REQ-025 The four lanes are independent; no lane's result depends on another lane.
REQ-026 aligned_sign and aligned_exp travel through both stages with their bundle, unmodified.
REQ-027 Back-to-back accepted bundles with out_ready held at 1 stream at one bundle per cycle.

Reset
REQ-028 rst_n=0 immediately clears S1 valid and out_valid to 0, and aligned_man, aligned_sign, aligned_exp to 0, independent of clk.
REQ-029 in_ready reads 1 during and after reset, because out_valid=0 there.
REQ-030 Reset asserted mid-stream discards all in-flight bundles; the first bundle accepted after rst_n rises appears 2 cycles later.

Verification
REQ-031 Zero shift: manWidth=4, lane0 man=4'b1011, off=0, out_ready=1 -> two cycles later lane0 = 7'b1011000, out_valid=1.
REQ-032 Shift with sticky: man=4'b1011, off=2/4/5/15 -> 7'b0010110 / 7'b0000101 / 7'b0000011 / 7'b0000001; man=0, off=15 -> 7'b0000000.
REQ-033 Stall: bundles A, B, C on consecutive cycles with out_ready=0 from when A reaches the output -> A held stable, in_ready=0, no loss; out_ready=1 -> A, B, C emitted in order, one per cycle.
REQ-034 Sideband: input_sign=4'b1010, max_exp=4'hC -> aligned_sign=4'b1010 and aligned_exp=4'hC in the same cycle as that bundle's aligned_man.
REQ-035 Reset mid-operation: drop rst_n while out_valid=1 and S1 is full -> out_valid=0 and outputs zero without a clock edge; no bundle emerges after release until a new input is accepted.
REQ-036 Throughput: 8 bundles with random offsets 0..15, in_valid=1, out_ready=1 -> 8 consecutive out_valid cycles, each bundle matching the reference model of REQ-022/023.
